// File: rtl/pm_pkg.sv
// Shared state encodings and output decode for the power-management reset sequencer.
package pm_pkg;

  localparam int PM_STATE_W = 3;

  typedef enum logic [PM_STATE_W-1:0] {
    PM_HOLD      = 3'd0,
    PM_WAIT_LOCK = 3'd1,
    PM_REL_IO    = 3'd2,
    PM_REL_CLK   = 3'd3,
    PM_REL_DP    = 3'd4,
    PM_RUN       = 3'd5
  } pm_state_e;

  typedef struct packed {
    logic io_rst;
    logic clk_rst;
    logic dp_rst;
    logic done;
  } pm_out_t;

  // Any encoding outside the release ladder keeps every reset asserted.
  function automatic pm_out_t pm_decode(input pm_state_e s);
    pm_out_t o;
    o = '{io_rst: 1'b1, clk_rst: 1'b1, dp_rst: 1'b1, done: 1'b0};
    case (s)
      PM_REL_IO:  o = '{io_rst: 1'b0, clk_rst: 1'b1, dp_rst: 1'b1, done: 1'b0};
      PM_REL_CLK: o = '{io_rst: 1'b0, clk_rst: 1'b0, dp_rst: 1'b1, done: 1'b0};
      PM_REL_DP:  o = '{io_rst: 1'b0, clk_rst: 1'b0, dp_rst: 1'b0, done: 1'b0};
      PM_RUN:     o = '{io_rst: 1'b0, clk_rst: 1'b0, dp_rst: 1'b0, done: 1'b1};
      default:    o = '{io_rst: 1'b1, clk_rst: 1'b1, dp_rst: 1'b1, done: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pm_sync_bit.sv
// Two-flop level synchronizer; both stages clear to 0 on synchronous reset.
module pm_sync_bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pm_reset_sequencer.sv
// Holds all resets, waits for a stable clock lock, then releases io, clk and
// datapath resets in order with programmable gaps; restarts on lock loss or soft reset.
module pm_reset_sequencer
  import pm_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int LOCK_STABLE = 32,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  dest_clk,
  input  logic                  rst_in,
  input  logic                  mmcm_locked,
  input  logic                  soft_rst_req,
  output logic                  io_rst_req,
  output logic                  clk_rst_req,
  output logic                  dp_rst,
  output logic                  seq_done,
  output logic [PM_STATE_W-1:0] seq_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic       locked_sync;
  pm_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pm_out_t    out_q;
  logic       abort;

  pm_sync_bit u_lock_sync (
    .clk_i (dest_clk),
    .rst_i (rst_in),
    .d_i   (mmcm_locked),
    .q_o   (locked_sync)
  );

  assign abort = !locked_sync || soft_rst_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      PM_HOLD: begin
        if (soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = PM_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      PM_WAIT_LOCK: begin
        // A lock drop only restarts the stability window; it never returns to HOLD.
        if (soft_rst_req) begin
          state_d = PM_HOLD;
          cnt_d   = '0;
        end else if (!locked_sync) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = PM_REL_IO;
          cnt_d   = '0;
        end
      end
      PM_REL_IO, PM_REL_CLK, PM_REL_DP: begin
        // Abort beats a stage end landing on the same cycle.
        if (abort) begin
          state_d = PM_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = (state_q == PM_REL_IO)  ? PM_REL_CLK :
                    (state_q == PM_REL_CLK) ? PM_REL_DP  : PM_RUN;
          cnt_d   = '0;
        end
      end
      PM_RUN: begin
        cnt_d = cnt_q;
        if (abort) begin
          state_d = PM_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PM_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they always match state_q.
  always_ff @(posedge dest_clk) begin
    if (rst_in) begin
      state_q <= PM_HOLD;
      cnt_q   <= '0;
      out_q   <= pm_decode(PM_HOLD);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= pm_decode(state_d);
    end
  end

  assign io_rst_req  = out_q.io_rst;
  assign clk_rst_req = out_q.clk_rst;
  assign dp_rst      = out_q.dp_rst;
  assign seq_done    = out_q.done;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_pm_reset_sequencer.sv
// Self-checking bench for pm_reset_sequencer with default parameters.
module tb_pm_reset_sequencer;

  logic       dest_clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       mmcm_locked = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       io_rst_req, clk_rst_req, dp_rst, seq_done;
  logic [2:0] seq_state;

  pm_reset_sequencer dut (
    .dest_clk     (dest_clk),
    .rst_in       (rst_in),
    .mmcm_locked  (mmcm_locked),
    .soft_rst_req (soft_rst_req),
    .io_rst_req   (io_rst_req),
    .clk_rst_req  (clk_rst_req),
    .dp_rst       (dp_rst),
    .seq_done     (seq_done),
    .seq_state    (seq_state)
  );

  always #5 dest_clk = ~dest_clk;

  typedef struct {
    int         k;
    logic [2:0] st;
    logic       io;
    logic       ck;
    logic       dp;
    logic       dn;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t pwr[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   base = 0;

  task automatic chk(input string nm, input int k, input logic [2:0] st,
                     input logic io, input logic ck, input logic dp, input logic dn);
    logic [6:0] got, want;
    got  = {seq_state, io_rst_req, clk_rst_req, dp_rst, seq_done};
    want = {st, io, ck, dp, dn};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at k=%0d: got state=%0d io=%b clk=%b dp=%b done=%b, want state=%0d io=%b clk=%b dp=%b done=%b",
               nm, k, got[6:4], got[3], got[2], got[1], got[0], st, io, ck, dp, dn);
    end
  endtask

  task automatic ex(input int k, input logic [2:0] st, input logic io, input logic ck,
                    input logic dp, input logic dn, input string nm);
    exp_t e;
    e.k = k; e.st = st; e.io = io; e.ck = ck; e.dp = dp; e.dn = dn; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge dest_clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].k <= cyc - base) begin
      e = sbq.pop_front();
      chk(e.nm, cyc - base, e.st, e.io, e.ck, e.dp, e.dn);
    end
  endtask

  task automatic run_until(input int k);
    while (cyc - base < k) tick();
  endtask

  // One reset edge; k counts edges after it.
  task automatic release_rst(input string nm);
    rst_in = 1'b1;
    tick();
    chk({nm, "_reset"}, 0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_in = 1'b0;
    base = cyc;
  endtask

  initial begin
    pwr.push_back('{1,   3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "pu_hold_first"});
    pwr.push_back('{15,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "pu_hold_last"});
    pwr.push_back('{16,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "pu_wait_first"});
    pwr.push_back('{47,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "pu_wait_last"});
    pwr.push_back('{48,  3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "pu_io_rel"});
    pwr.push_back('{55,  3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "pu_io_last"});
    pwr.push_back('{56,  3'd3, 1'b0, 1'b0, 1'b1, 1'b0, "pu_clk_rel"});
    pwr.push_back('{63,  3'd3, 1'b0, 1'b0, 1'b1, 1'b0, "pu_clk_last"});
    pwr.push_back('{64,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0, "pu_dp_rel"});
    pwr.push_back('{71,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0, "pu_dp_last"});
    pwr.push_back('{72,  3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "pu_run"});
    pwr.push_back('{100, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "pu_run_stay"});

    repeat (3) tick();
    chk("por_reset", 0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Power-up with lock present from the start
    release_rst("pu");
    for (int i = 0; i < pwr.size(); i++) sbq.push_back(pwr[i]);
    run_until(100);

    // Lock absent for 100 cycles beyond HOLD
    mmcm_locked = 1'b0;
    release_rst("nolock");
    ex(16,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "nolock_wait");
    ex(116, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "nolock_wait_long");
    run_until(116);
    mmcm_locked = 1'b1;
    ex(149, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "relock_before");
    ex(150, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "relock_io_rel");
    run_until(150);

    // Single-cycle lock glitch in WAIT_LOCK
    release_rst("glitch");
    ex(36, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "glitch_wait");
    run_until(36);
    mmcm_locked = 1'b0;
    tick();
    mmcm_locked = 1'b1;
    ex(48, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "glitch_no_early_rel");
    ex(70, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "glitch_before");
    ex(71, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "glitch_io_rel");
    run_until(71);

    // Lock loss in RUN, then replay
    release_rst("runloss");
    ex(80, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "runloss_run");
    run_until(80);
    mmcm_locked = 1'b0;
    ex(82,  3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "runloss_sync_lat");
    ex(83,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "runloss_hold");
    run_until(83);
    mmcm_locked = 1'b1;
    ex(130, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "replay_wait");
    ex(131, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "replay_io_rel");
    ex(155, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "replay_run");
    run_until(155);

    // Soft reset on the REL_CLK stage-end cycle
    release_rst("soft_clk");
    ex(63, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, "soft_clk_stage_end");
    run_until(63);
    soft_rst_req = 1'b1;
    ex(64, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "soft_clk_abort");
    tick();
    soft_rst_req = 1'b0;
    ex(79,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "soft_clk_hold_full");
    ex(80,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "soft_clk_wait");
    ex(112, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "soft_clk_io_rel");
    run_until(112);

    // Soft reset in HOLD extends the hold
    release_rst("soft_hold");
    run_until(10);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    ex(26, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "soft_hold_ext");
    ex(27, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "soft_hold_wait");
    run_until(27);

    // Soft reset in WAIT_LOCK returns to HOLD
    release_rst("soft_wait");
    run_until(30);
    soft_rst_req = 1'b1;
    ex(31, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "soft_wait_hold");
    tick();
    soft_rst_req = 1'b0;
    ex(46, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "soft_wait_hold_last");
    ex(47, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "soft_wait_rewait");
    ex(79, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "soft_wait_io_rel");
    run_until(79);

    // One-cycle rst_in pulse in RUN
    release_rst("midrst");
    ex(80, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, "midrst_run");
    run_until(80);
    rst_in = 1'b1;
    ex(81, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "midrst_hold");
    tick();
    rst_in = 1'b0;
    ex(96,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, "midrst_hold_last");
    ex(97,  3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "midrst_wait");
    ex(128, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, "midrst_wait_last");
    ex(129, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, "midrst_io_rel");
    run_until(129);

    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
